// File: rtl/led_fade_controller.sv
// led_fade_controller
// -------------------
// Command-driven brightness sequencer that feeds a PWM generator. A host sends
// commands over a valid/ready handshake. Each command either sets the level at
// once, fades linearly to a target, or breathes continuously between 0 and a
// peak. Each command carries its own step period, and an internal prescaler
// paces the steps from it.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   cmd_valid   command present
//   cmd_ready   controller can accept a command this cycle; low only while fading
//   cmd_mode    0=SET, 1=FADE, 2=BREATHE, 3=reserved (accepted and ignored)
//   cmd_target  target level (FADE/SET) or peak level (BREATHE)
//   cmd_rate    clocks per step minus one
//   brightness  registered level to the PWM generator
//   busy        high whenever the sequencer is not idle
//   done        one-cycle pulse when a SET or FADE completes

module led_fade_controller #(
  parameter int WIDTH      = 16,
  parameter int RATE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_mode,
  input  logic [WIDTH-1:0]      cmd_target,
  input  logic [RATE_WIDTH-1:0] cmd_rate,
  output logic [WIDTH-1:0]      brightness,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_FADE         = 2'd1,
    ST_BREATHE_UP   = 2'd2,
    ST_BREATHE_DOWN = 2'd3
  } state_t;

  localparam logic [1:0] MODE_SET     = 2'd0;
  localparam logic [1:0] MODE_FADE    = 2'd1;
  localparam logic [1:0] MODE_BREATHE = 2'd2;

  localparam logic [WIDTH-1:0]      ZERO_LEVEL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]      ONE_LEVEL  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RATE_WIDTH-1:0] ZERO_TICK  = {RATE_WIDTH{1'b0}};
  localparam logic [RATE_WIDTH-1:0] ONE_TICK   = {{(RATE_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_r;
  logic [WIDTH-1:0]        brightness_r;
  logic [WIDTH-1:0]        target_r;
  logic [RATE_WIDTH-1:0]   rate_r;
  logic [RATE_WIDTH-1:0]   tick_r;
  logic                    done_r;
  logic                    busy_r;
  logic                    cmd_ready_r;

  logic                    accept_s;
  logic                    step_s;
  logic [WIDTH-1:0]        bright_inc_s;
  logic [WIDTH-1:0]        bright_dec_s;

  // Next values produced by the effect that is currently running.
  state_t                  eff_state_s;
  logic [WIDTH-1:0]        eff_bright_s;
  logic [RATE_WIDTH-1:0]   eff_tick_s;
  logic                    eff_done_s;

  // Final next values after a possible new command is folded in.
  state_t                  state_nxt_s;
  logic [WIDTH-1:0]        bright_nxt_s;
  logic [WIDTH-1:0]        target_nxt_s;
  logic [RATE_WIDTH-1:0]   rate_nxt_s;
  logic [RATE_WIDTH-1:0]   tick_nxt_s;
  logic                    done_nxt_s;

  assign accept_s     = cmd_valid && cmd_ready_r;
  assign step_s       = (tick_r == ZERO_TICK);
  assign bright_inc_s = brightness_r + ONE_LEVEL;
  assign bright_dec_s = brightness_r - ONE_LEVEL;

  assign brightness = brightness_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign cmd_ready  = cmd_ready_r;

  // Advance the running effect by one clock: prescaler countdown and +/-1 steps.
  always_comb begin
    eff_state_s  = state_r;
    eff_bright_s = brightness_r;
    eff_tick_s   = tick_r;
    eff_done_s   = 1'b0;
    case (state_r)
      ST_FADE: begin
        if (step_s) begin
          eff_tick_s = rate_r;
          if (brightness_r < target_r) begin
            eff_bright_s = bright_inc_s;
            if (bright_inc_s == target_r) begin
              eff_done_s  = 1'b1;
              eff_state_s = ST_IDLE;
            end else begin
              eff_state_s = ST_FADE;
            end
          end else if (brightness_r > target_r) begin
            eff_bright_s = bright_dec_s;
            if (bright_dec_s == target_r) begin
              eff_done_s  = 1'b1;
              eff_state_s = ST_IDLE;
            end else begin
              eff_state_s = ST_FADE;
            end
          end else begin
            // Already on target: finish without moving.
            eff_done_s  = 1'b1;
            eff_state_s = ST_IDLE;
          end
        end else begin
          eff_tick_s = tick_r - ONE_TICK;
        end
      end
      ST_BREATHE_UP: begin
        if (step_s) begin
          eff_tick_s = rate_r;
          if (brightness_r < target_r) begin
            eff_bright_s = bright_inc_s;
            // Turn around on the very edge the peak is reached.
            if (bright_inc_s == target_r) begin
              eff_state_s = ST_BREATHE_DOWN;
            end else begin
              eff_state_s = ST_BREATHE_UP;
            end
          end else begin
            eff_state_s = ST_BREATHE_DOWN;
          end
        end else begin
          eff_tick_s = tick_r - ONE_TICK;
        end
      end
      ST_BREATHE_DOWN: begin
        if (step_s) begin
          eff_tick_s = rate_r;
          if (brightness_r != ZERO_LEVEL) begin
            eff_bright_s = bright_dec_s;
            if (bright_dec_s == ZERO_LEVEL) begin
              eff_state_s = ST_BREATHE_UP;
            end else begin
              eff_state_s = ST_BREATHE_DOWN;
            end
          end else begin
            eff_state_s = ST_BREATHE_UP;
          end
        end else begin
          eff_tick_s = tick_r - ONE_TICK;
        end
      end
      default: begin
        // Idle: hold everything.
        eff_state_s = ST_IDLE;
      end
    endcase
  end

  // Fold an accepted command over the running effect; a new command wins.
  always_comb begin
    state_nxt_s  = eff_state_s;
    bright_nxt_s = eff_bright_s;
    tick_nxt_s   = eff_tick_s;
    done_nxt_s   = eff_done_s;
    target_nxt_s = target_r;
    rate_nxt_s   = rate_r;
    if (accept_s) begin
      case (cmd_mode)
        MODE_SET: begin
          state_nxt_s  = ST_IDLE;
          bright_nxt_s = cmd_target;
          tick_nxt_s   = tick_r;
          done_nxt_s   = 1'b1;
        end
        MODE_FADE: begin
          target_nxt_s = cmd_target;
          rate_nxt_s   = cmd_rate;
          tick_nxt_s   = cmd_rate;
          bright_nxt_s = brightness_r;
          if (cmd_target == brightness_r) begin
            state_nxt_s = ST_IDLE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = ST_FADE;
            done_nxt_s  = 1'b0;
          end
        end
        MODE_BREATHE: begin
          target_nxt_s = cmd_target;
          rate_nxt_s   = cmd_rate;
          tick_nxt_s   = cmd_rate;
          bright_nxt_s = brightness_r;
          if (cmd_target == ZERO_LEVEL) begin
            // A zero peak degenerates into a fade to 0.
            if (brightness_r == ZERO_LEVEL) begin
              state_nxt_s = ST_IDLE;
              done_nxt_s  = 1'b1;
            end else begin
              state_nxt_s = ST_FADE;
              done_nxt_s  = 1'b0;
            end
          end else if (brightness_r < cmd_target) begin
            state_nxt_s = ST_BREATHE_UP;
            done_nxt_s  = 1'b0;
          end else begin
            state_nxt_s = ST_BREATHE_DOWN;
            done_nxt_s  = 1'b0;
          end
        end
        default: begin
          // Reserved mode: consumed, running effect continues untouched.
          state_nxt_s = eff_state_s;
        end
      endcase
    end else begin
      state_nxt_s = eff_state_s;
    end
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      brightness_r <= ZERO_LEVEL;
      target_r     <= ZERO_LEVEL;
      rate_r       <= ZERO_TICK;
      tick_r       <= ZERO_TICK;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
      cmd_ready_r  <= 1'b1;
    end else begin
      state_r      <= state_nxt_s;
      brightness_r <= bright_nxt_s;
      target_r     <= target_nxt_s;
      rate_r       <= rate_nxt_s;
      tick_r       <= tick_nxt_s;
      done_r       <= done_nxt_s;
      busy_r       <= (state_nxt_s != ST_IDLE);
      // Breathing may be interrupted; a fade must run to completion.
      cmd_ready_r  <= (state_nxt_s != ST_FADE);
    end
  end

endmodule

// File: tb/tb_led_fade_controller.sv
// Table-driven bench for led_fade_controller. Each vector holds the inputs
// driven for one clock and the outputs expected just after that clock edge.
module tb_led_fade_controller;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mode;
  logic [15:0] cmd_target;
  logic [7:0]  cmd_rate;
  logic [15:0] brightness;
  logic        busy;
  logic        done;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic        valid;
    logic [1:0]  mode;
    logic [15:0] target;
    logic [7:0]  rate;
    logic [15:0] exp_bright;
    logic        exp_busy;
    logic        exp_done;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[$];

  led_fade_controller #(.WIDTH(16), .RATE_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_target (cmd_target),
    .cmd_rate   (cmd_rate),
    .brightness (brightness),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic v, input logic [1:0] m, input logic [15:0] t,
                     input logic [7:0] r, input logic [15:0] eb, input logic ebusy,
                     input logic edone, input logic erdy);
    vec_t x;
    x.valid = v; x.mode = m; x.target = t; x.rate = r;
    x.exp_bright = eb; x.exp_busy = ebusy; x.exp_done = edone; x.exp_ready = erdy;
    vecs.push_back(x);
  endtask

  task automatic idle(input logic [15:0] eb, input logic ebusy, input logic edone,
                      input logic erdy);
    add(1'b0, 2'd0, 16'h0000, 8'd0, eb, ebusy, edone, erdy);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic [15:0] eb,
                           input logic ebusy, input logic edone, input logic erdy);
    check({tag, ".brightness"}, idx, {16'd0, brightness}, {16'd0, eb});
    check({tag, ".busy"},       idx, {31'd0, busy},       {31'd0, ebusy});
    check({tag, ".done"},       idx, {31'd0, done},       {31'd0, edone});
    check({tag, ".cmd_ready"},  idx, {31'd0, cmd_ready},  {31'd0, erdy});
  endtask

  // Drive one clock of inputs at the falling edge, sample 1 ns after the rising edge.
  task automatic apply(input logic v, input logic [1:0] m, input logic [15:0] t,
                       input logic [7:0] r);
    @(negedge clk);
    cmd_valid = v; cmd_mode = m; cmd_target = t; cmd_rate = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_mode     = 2'd0;
    cmd_target   = 16'h0000;
    cmd_rate     = 8'd0;

    // Reset then 10 idle cycles.
    for (int i = 0; i < 10; i++) idle(16'h0000, 1'b0, 1'b0, 1'b1);
    // SET 0x1234, then done drops.
    add(1'b1, 2'd0, 16'h1234, 8'd0, 16'h1234, 1'b0, 1'b1, 1'b1);
    idle(16'h1234, 1'b0, 1'b0, 1'b1);
    // Back to 0, then FADE to 4 at rate 2: one step every 3 clocks.
    add(1'b1, 2'd0, 16'h0000, 8'd0, 16'h0000, 1'b0, 1'b1, 1'b1);
    add(1'b1, 2'd1, 16'h0004, 8'd2, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++)
      idle(16'(i / 3), (i < 12), (i == 12), (i == 12));
    idle(16'h0004, 1'b0, 1'b0, 1'b1);
    // From 10, FADE to 7 at rate 0 with a SET held pending the whole time.
    add(1'b1, 2'd0, 16'h000a, 8'd0, 16'h000a, 1'b0, 1'b1, 1'b1);
    add(1'b1, 2'd1, 16'h0007, 8'd0, 16'h000a, 1'b1, 1'b0, 1'b0);
    add(1'b1, 2'd0, 16'h0055, 8'd0, 16'h0009, 1'b1, 1'b0, 1'b0);
    add(1'b1, 2'd0, 16'h0055, 8'd0, 16'h0008, 1'b1, 1'b0, 1'b0);
    add(1'b1, 2'd0, 16'h0055, 8'd0, 16'h0007, 1'b0, 1'b1, 1'b1);
    add(1'b1, 2'd0, 16'h0055, 8'd0, 16'h0055, 1'b0, 1'b1, 1'b1);
    idle(16'h0055, 1'b0, 1'b0, 1'b1);
    // From 0, BREATHE peak 3 at rate 0, then interrupt with SET 0x20.
    add(1'b1, 2'd0, 16'h0000, 8'd0, 16'h0000, 1'b0, 1'b1, 1'b1);
    add(1'b1, 2'd2, 16'h0003, 8'd0, 16'h0000, 1'b1, 1'b0, 1'b1);
    idle(16'd1, 1'b1, 1'b0, 1'b1);
    idle(16'd2, 1'b1, 1'b0, 1'b1);
    idle(16'd3, 1'b1, 1'b0, 1'b1);
    idle(16'd2, 1'b1, 1'b0, 1'b1);
    idle(16'd1, 1'b1, 1'b0, 1'b1);
    idle(16'd0, 1'b1, 1'b0, 1'b1);
    idle(16'd1, 1'b1, 1'b0, 1'b1);
    idle(16'd2, 1'b1, 1'b0, 1'b1);
    idle(16'd3, 1'b1, 1'b0, 1'b1);
    add(1'b1, 2'd0, 16'h0020, 8'd0, 16'h0020, 1'b0, 1'b1, 1'b1);
    idle(16'h0020, 1'b0, 1'b0, 1'b1);
    // Reserved mode is consumed without effect.
    add(1'b1, 2'd3, 16'h0099, 8'd5, 16'h0020, 1'b0, 1'b0, 1'b1);
    idle(16'h0020, 1'b0, 1'b0, 1'b1);
    // Back-to-back SETs: one done each.
    add(1'b1, 2'd0, 16'h0030, 8'd0, 16'h0030, 1'b0, 1'b1, 1'b1);
    add(1'b1, 2'd0, 16'h0031, 8'd0, 16'h0031, 1'b0, 1'b1, 1'b1);
    idle(16'h0031, 1'b0, 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 16'h0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].valid, vecs[i].mode, vecs[i].target, vecs[i].rate);
      check_all("vec", i, vecs[i].exp_bright, vecs[i].exp_busy,
                vecs[i].exp_done, vecs[i].exp_ready);
    end

    // Reset in the middle of a fade once brightness reaches 50.
    apply(1'b1, 2'd0, 16'd40, 8'd0);
    check_all("seq.set40", 0, 16'd40, 1'b0, 1'b1, 1'b1);
    apply(1'b1, 2'd1, 16'd60, 8'd0);
    for (int i = 0; i < 10; i++) apply(1'b0, 2'd0, 16'h0000, 8'd0);
    check_all("seq.at50", 0, 16'd50, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all("seq.midreset", 0, 16'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    apply(1'b0, 2'd0, 16'h0000, 8'd0);
    check_all("seq.postreset", 0, 16'd0, 1'b0, 1'b0, 1'b1);

    // FADE to the current level finishes at once with no steps.
    apply(1'b1, 2'd0, 16'd50, 8'd0);
    check_all("seq.set50", 0, 16'd50, 1'b0, 1'b1, 1'b1);
    apply(1'b1, 2'd1, 16'd50, 8'd3);
    check_all("seq.fade_eq", 0, 16'd50, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 2'd0, 16'h0000, 8'd0);
      check_all("seq.fade_eq_hold", i, 16'd50, 1'b0, 1'b0, 1'b1);
    end

    // BREATHE with zero peak from 2 acts as a fade to 0.
    apply(1'b1, 2'd0, 16'd2, 8'd0);
    apply(1'b1, 2'd2, 16'd0, 8'd0);
    check_all("seq.br0.accept", 0, 16'd2, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 2'd0, 16'h0000, 8'd0);
    check_all("seq.br0.s1", 0, 16'd1, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 2'd0, 16'h0000, 8'd0);
    check_all("seq.br0.s2", 0, 16'd0, 1'b0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
